// File: rtl/external_bus_interface.sv
`default_nettype none
// ============================================================================
// Module  : external_bus_interface
// Purpose : Latches a core bus request and runs a four-phase req/ack handshake
//           with the external responder, stalling the core until completion.
//           Optional REQ-state timeout enabled by defining BUS_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module external_bus_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] core_addr,
    input  logic [7:0]  core_wdata,
    input  logic        core_rw,
    input  logic        core_start,
    output logic [7:0]  core_rdata,
    output logic        core_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_rw;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_mem_we;
    logic        r_mem_req;
    logic [7:0]  r_rdata;
    logic        w_accept;
    logic        w_timeout;

    assign w_accept = (r_state == S_IDLE) && core_start;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] c_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_inc;
    logic       r_bus_error;

    assign w_cnt_inc = r_cnt + 8'd1;
    // Ack takes priority over the limit on the same edge.
    assign w_timeout = (r_state == S_REQ) && !mem_ack && (w_cnt_inc == c_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 8'd0;
            r_bus_error <= 1'b0;
        end else if (w_accept) begin
            r_cnt       <= 8'd0;
            r_bus_error <= 1'b0;
        end else if ((r_state == S_REQ) && !mem_ack) begin
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign bus_error = r_bus_error;
`else
    logic [7:0] w_unused_limit;
    assign w_unused_limit = 8'(TIMEOUT_CYCLES);
    assign w_timeout      = 1'b0;
    assign bus_error      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (core_start)            w_next_state = S_REQ;
            S_REQ:     if (mem_ack || w_timeout)  w_next_state = S_RELEASE;
            S_RELEASE: if (!mem_ack)              w_next_state = S_IDLE;
            default:                              w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rw        <= 1'b1;
            r_mem_addr  <= 16'hFF00;
            r_mem_wdata <= 8'h00;
            r_mem_we    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_rdata     <= 8'h00;
        end else if (w_accept) begin
            r_rw        <= core_rw;
            r_mem_addr  <= core_addr;
            r_mem_wdata <= core_wdata;
            r_mem_req   <= 1'b1;
            r_mem_we    <= ~core_rw;
        end else if (r_state == S_REQ) begin
            if (mem_ack) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (r_rw) begin
                    r_rdata <= mem_rdata;
                end
            end else if (w_timeout) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (r_rw) begin
                    r_rdata <= 8'hFF;
                end
            end
        end
    end

    assign core_ready = (r_state == S_IDLE);
    assign core_rdata = r_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;
    assign mem_req    = r_mem_req;

endmodule
`default_nettype wire

// File: doc/external_bus_interface.md
# external_bus_interface

Sequencer between the CPU's internal dataflow and the external memory/peripheral bus. It latches the 16-bit address (ABH/ABL) and DOR write data when a bus cycle starts, runs a four-phase req/ack handshake with the external responder, and captures read data into the input data latch feeding `externalDBRead`. It drives `core_ready` low to stall the timing controller until the cycle completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: REQ-state cycles before abort. Range 1–255. Used only with `BUS_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `core_addr`  in  16  {ABH, ABL} from the dataflow.
- `core_wdata`  in  8  DOR contents.
- `core_rw`  in  1  1 = read, 0 = write.
- `core_start`  in  1  request a bus cycle. Sampled only in IDLE.
- `core_rdata`  out  8  read data latch. Drives `externalDBRead`.
- `core_ready`  out  1  high only in IDLE. Core stalls while low.
- `mem_addr`  out  16  latched address.
- `mem_wdata`  out  8  latched write data.
- `mem_we`  out  1  write strobe. Qualified by `mem_req`.
- `mem_req`  out  1  handshake request.
- `mem_ack`  in  1  handshake acknowledge.
- `mem_rdata`  in  8  responder read data. Valid while `mem_ack` = 1.
- `bus_error`  out  1  sticky timeout flag.

## Operation
- FSM states:
  - IDLE: `core_ready` = 1. On `core_start`:
    - latch `core_addr`, `core_wdata` and `core_rw`;
    - go to REQ.
  - REQ: `mem_req` = 1. `mem_we` = ~latched rw.
    - On `mem_ack` = 1: if the cycle is a read, capture `mem_rdata` into `core_rdata`. Then go to RELEASE.
  - RELEASE: `mem_req` = 0, `mem_we` = 0.
    - On `mem_ack` = 0: go to IDLE.
- All `mem_*` outputs are registered. `mem_addr` and `mem_wdata` hold their values from the latch edge until the next `core_start` accepted in IDLE.
- `core_rdata` changes only on read completion, on a timeout, or on reset. Writes leave it untouched.
- `core_start` outside IDLE is ignored. No queueing.
- `mem_ack` in IDLE is ignored (spurious).
- `bus_error` clears on the next accepted `core_start`.

## Timing
Reset values (asynchronous, applied immediately):
- state IDLE
- `mem_req` 0, `mem_we` 0
- `mem_addr` 16'hFF00, `mem_wdata` 8'h00
- `core_rdata` 8'h00, `bus_error` 0, timeout counter 0

Cycle behaviour:
- `core_start` sampled at edge E0 produces REQ from E0. `mem_req` = 1 and `core_ready` = 0 in the cycle after E0.
- `mem_ack` sampled high at edge Ea produces the following from Ea:
  - `mem_req` = 0;
  - `core_rdata` valid.
- `mem_ack` sampled low at edge Eb gives IDLE and `core_ready` = 1 from Eb. The core may start a new cycle in that same ready cycle.
- Minimum with a zero-wait responder (ack combinational on req, drop combinational on ~req): 3 edges from start to ready.
- Reset mid-cycle: `mem_req` drops asynchronously and the transaction is abandoned. The responder must tolerate a req withdrawn before ack.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter equals `TIMEOUT_CYCLES`:
    - for a read, set `core_rdata` = 8'hFF;
    - set `bus_error` = 1;
    - go to RELEASE.
  - If ack arrives on the same edge as the limit, ack wins: normal completion, no error.
- `BUS_TIMEOUT_EN` undefined: no counter. REQ waits indefinitely. `bus_error` is tied to 0.

## Test plan
- Reset: assert `rst` mid-REQ → same cycle `mem_req` = 0, `mem_addr` = 16'hFF00, `core_rdata` = 00, `core_ready` = 1.
- Zero-wait read: `core_start`, rw = 1, addr 16'h1234, responder returns 8'hA5 → `mem_addr` = 1234, `core_rdata` = A5 at edge 2, `core_ready` back at edge 3.
- Write with 4 wait states: addr 16'h0200, wdata 8'h3C → `mem_we` = `mem_req` = 1 for 5 cycles, data 3C stable throughout, `core_rdata` unchanged.
- Back-to-back: new `core_start` on the first ready cycle, plus `core_start` pulses during REQ → only the IDLE-sampled start is accepted. Two transactions total.
- Slow ack release: ack held high 3 cycles after `mem_req` drops → `core_ready` stays 0 until ack falls.
- `BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4, read with no ack → after 4 REQ cycles `core_rdata` = FF, `bus_error` = 1. Next start clears `bus_error`. Ack on the limit edge → no error.
